axi_rd_burst_split: RTL and testbench
=====================================

Name: axi_rd_burst_split

Overview:
AXI4 read-channel adapter placed directly upstream of the read-data FIFO on the master side. It splits long INCR read bursts into sub-bursts of at most MAX_BURST_LEN beats, so a FIFO_DELAY-enabled read FIFO can always hold a complete sub-burst. On the R channel it merges the sub-burst responses so the upstream master sees one burst with a single RLAST. R data is passed through without buffering.

Parameters:
DATA_WIDTH, 32, data bus width in bits
ADDR_WIDTH, 32, address width in bits
ID_WIDTH, 8, ID width
MAX_BURST_LEN, 16, maximum beats per issued sub-burst; power of 2, range 1..256
MAX_OUTSTANDING, 4, original bursts tracked at once; power of 2, range 2..32

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous assert, active-low
s_axi_arid/araddr/arlen/arsize/arburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  slave AR request fields
s_axi_arlock/arcache/arprot  in  1/4/3  AR sideband, forwarded unchanged
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready (registered)
s_axi_rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_WIDTH/2/1  merged R beat
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready
m_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  out  same widths  issued sub-burst (registered)
m_axi_arvalid  out  1  AR valid (registered)
m_axi_arready  in  1  AR ready
m_axi_rid/rdata/rresp/rlast  in  ID_WIDTH/DATA_WIDTH/2/1  downstream R beat
m_axi_rvalid  in  1  R valid
m_axi_rready  out  1  R ready

Behaviour:
- Reset: one clock, clk. Reset rst_n is asynchronous and active-low.
  - While rst_n=0: s_axi_arready=0, m_axi_arvalid=0, FSM=IDLE, tracking FIFO empty, sub-burst counter=0.
  - Reset mid-split discards the remaining sub-bursts. There is no recovery of in-flight responses; the whole subsystem is reset together.
- AR FSM, IDLE:
  - s_axi_arready=1 when the m_axi_ar register is free (m_axi_arvalid=0, or it is being accepted this cycle) and the tracking FIFO is not full.
  - On s_axi_ar handshake, compute beats = arlen+1 (9-bit) and n_sub = ceil(beats/MAX_BURST_LEN).
  - If arburst != INCR (2'b01), or beats <= MAX_BURST_LEN, then n_sub = 1 and the request is forwarded unchanged.
  - Otherwise load: m_axi_arlen = MAX_BURST_LEN-1, remaining = beats-MAX_BURST_LEN, next_addr = araddr + (MAX_BURST_LEN << arsize) mod 2^ADDR_WIDTH. Then go to SPLIT.
  - In both cases push n_sub-1 into the tracking FIFO and drop arready to 0 for the next cycle.
- AR FSM, SPLIT:
  - Each time m_axi_arready && m_axi_arvalid, issue the next sub-burst from next_addr.
  - Its length is min(remaining, MAX_BURST_LEN)-1. Subtract that from remaining and advance next_addr.
  - Return to IDLE after issuing the sub-burst that takes remaining to 0.
  - id, size, burst, lock, cache and prot are held constant for all sub-bursts.
- AR handshake rules: m_axi_arvalid stays high until accepted. AR fields are stable while valid && !ready. Throughput is one sub-burst per cycle under continuous m_axi_arready.
- R path: combinational pass-through.
  - s_axi_rvalid = m_axi_rvalid; m_axi_rready = s_axi_rready.
  - rid, rdata and rresp pass through per beat.
  - s_axi_rlast = m_axi_rlast && (sub_cnt == tracking head).
- R sub-burst tracking, on each R handshake with m_axi_rlast=1:
  - If sub_cnt == head: pop the tracking FIFO and set sub_cnt=0.
  - Else increment sub_cnt.
  - sub_cnt is 8 bits wide.
- Tracking FIFO:
  - MAX_OUTSTANDING entries, 8 bits each.
  - A push and a pop in the same cycle are both performed.
  - When full, s_axi_arready=0.
  - m_axi_rvalid while the FIFO is empty is a protocol violation; behaviour is undefined.
- Ordering: downstream must return R bursts in AR issue order. The system either uses a single ID or the slave is in-order; this is a usage requirement. Sub-bursts of one original burst share an ID and are therefore ordered.
- No 4 KB check is performed: sub-bursts stay inside the original legal burst.

Test Plan:
- INCR, araddr=0x1000, arlen=63, arsize=2, MAX_BURST_LEN=16 -> four m_ar with addr 0x1000/0x1040/0x1080/0x10C0, arlen=15 each, same id. 64 R beats; s_axi_rlast high only on beat 64.
- INCR, arlen=20, araddr=0x2004, arsize=3 -> m_ar (0x2004, len 15) then (0x2084, len 4). s_rlast only on beat 21; the downstream rlast on beat 16 is suppressed.
- FIXED, arlen=31; then INCR, arlen=0 -> each forwarded as a single unchanged m_ar; rlast passes through.
- m_axi_arready held low 10 cycles during SPLIT -> m_axi_ar fields stable and arvalid held; no sub-burst lost or duplicated.
- MAX_OUTSTANDING=4, five arlen=0 requests with rvalid held low -> fifth s_axi_arready stays 0 until the first R beat with rlast completes. rresp=SLVERR on one mid-burst beat is passed through unchanged under random s_axi_rready backpressure.
- rst_n pulsed low mid-SPLIT (asynchronously, between clock edges) -> m_axi_arvalid=0 and s_axi_arready=0 immediately. After release, a new arlen=31 request splits correctly into two len-15 sub-bursts.

Source files
------------

// File: rtl/axi_rd_burst_split.sv
// AXI4 read burst splitter: long INCR bursts leave as sub-bursts of at most
// MAX_BURST_LEN beats; their R responses are merged back into one upstream burst.
module axi_rd_burst_split #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = 8,
  parameter int MAX_BURST_LEN   = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  o_dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid && ready; once
  // valid is high it stays high with stable fields until that edge.
  localparam int LEN_SHIFT = $clog2(MAX_BURST_LEN);
  localparam int PTR_W     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W     = PTR_W + 1;
  localparam logic [8:0]       MBL   = 9'(MAX_BURST_LEN);
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {ST_IDLE = 1'b0, ST_SPLIT = 1'b1} state_t;
  state_t r_state, w_state_nxt;

  logic                  r_s_arready, r_m_arvalid;
  logic [ID_WIDTH-1:0]   r_m_arid;
  logic [ADDR_WIDTH-1:0] r_m_araddr, r_next_addr;
  logic [7:0]            r_m_arlen;
  logic [2:0]            r_m_arsize;
  logic [1:0]            r_m_arburst;
  logic                  r_m_arlock;
  logic [3:0]            r_m_arcache;
  logic [2:0]            r_m_arprot;
  logic [8:0]            r_remaining;
  logic [7:0]            r_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      r_wptr, r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic [7:0]            r_sub_cnt;

  logic                  w_s_hs, w_m_hs, w_do_split, w_issue_next, w_last_sub;
  logic                  w_r_last_hs, w_push, w_pop;
  logic                  w_m_arvalid_nxt, w_s_arready_nxt;
  logic [8:0]            w_beats, w_chunk;
  logic [7:0]            w_nsub_m1, w_head;
  logic [ADDR_WIDTH-1:0] w_step_in, w_step_hold;
  logic [CNT_W-1:0]      w_count_nxt;

  assign w_s_hs       = s_axi_arvalid & r_s_arready;
  assign w_m_hs       = r_m_arvalid & m_axi_arready;
  assign w_beats      = {1'b0, s_axi_arlen} + 9'd1;
  assign w_do_split   = (s_axi_arburst == 2'b01) && (w_beats > MBL);
  // Sub-burst count minus one: MAX_BURST_LEN is a power of two, so a shift.
  assign w_nsub_m1    = w_do_split ? (s_axi_arlen >> LEN_SHIFT) : 8'd0;
  assign w_step_in    = ADDR_WIDTH'(MAX_BURST_LEN) << s_axi_arsize;
  assign w_step_hold  = ADDR_WIDTH'(MAX_BURST_LEN) << r_m_arsize;
  assign w_chunk      = (r_remaining > MBL) ? MBL : r_remaining;
  assign w_last_sub   = (w_chunk == r_remaining);
  assign w_issue_next = (r_state == ST_SPLIT) && w_m_hs;

  assign w_head       = r_fifo[r_rptr];
  assign w_r_last_hs  = m_axi_rvalid & s_axi_rready & m_axi_rlast;
  assign w_push       = w_s_hs;
  assign w_pop        = w_r_last_hs && (r_sub_cnt == w_head);
  assign w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_s_hs && w_do_split) w_state_nxt = ST_SPLIT;
      ST_SPLIT: if (w_issue_next && w_last_sub) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // arready is only raised when the AR register will be empty next cycle.
  always_comb begin
    w_m_arvalid_nxt = r_m_arvalid;
    if (w_s_hs || (r_state == ST_SPLIT)) w_m_arvalid_nxt = 1'b1;
    else if (w_m_hs)                     w_m_arvalid_nxt = 1'b0;
    w_s_arready_nxt = (w_state_nxt == ST_IDLE) && !w_m_arvalid_nxt && (w_count_nxt < DEPTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_arready <= 1'b0;
      r_m_arvalid <= 1'b0;
      r_m_arid    <= '0;
      r_m_araddr  <= '0;
      r_m_arlen   <= '0;
      r_m_arsize  <= '0;
      r_m_arburst <= '0;
      r_m_arlock  <= 1'b0;
      r_m_arcache <= '0;
      r_m_arprot  <= '0;
      r_remaining <= '0;
      r_next_addr <= '0;
    end else begin
      r_s_arready <= w_s_arready_nxt;
      r_m_arvalid <= w_m_arvalid_nxt;
      if (w_s_hs) begin
        r_m_arid    <= s_axi_arid;
        r_m_araddr  <= s_axi_araddr;
        r_m_arlen   <= w_do_split ? 8'(MBL - 9'd1) : s_axi_arlen;
        r_m_arsize  <= s_axi_arsize;
        r_m_arburst <= s_axi_arburst;
        r_m_arlock  <= s_axi_arlock;
        r_m_arcache <= s_axi_arcache;
        r_m_arprot  <= s_axi_arprot;
        r_remaining <= w_do_split ? (w_beats - MBL) : 9'd0;
        r_next_addr <= s_axi_araddr + w_step_in;
      end else if (w_issue_next) begin
        r_m_araddr  <= r_next_addr;
        r_m_arlen   <= 8'(w_chunk - 9'd1);
        r_remaining <= r_remaining - w_chunk;
        r_next_addr <= r_next_addr + w_step_hold;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= w_nsub_m1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_sub_cnt <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      if (w_r_last_hs) r_sub_cnt <= w_pop ? 8'd0 : r_sub_cnt + 8'd1;
    end
  end

  assign s_axi_arready = r_s_arready;
  assign m_axi_arvalid = r_m_arvalid;
  assign m_axi_arid    = r_m_arid;
  assign m_axi_araddr  = r_m_araddr;
  assign m_axi_arlen   = r_m_arlen;
  assign m_axi_arsize  = r_m_arsize;
  assign m_axi_arburst = r_m_arburst;
  assign m_axi_arlock  = r_m_arlock;
  assign m_axi_arcache = r_m_arcache;
  assign m_axi_arprot  = r_m_arprot;

  assign s_axi_rvalid  = m_axi_rvalid;
  assign m_axi_rready  = s_axi_rready;
  assign s_axi_rid     = m_axi_rid;
  assign s_axi_rdata   = m_axi_rdata;
  assign s_axi_rresp   = m_axi_rresp;
  assign s_axi_rlast   = m_axi_rlast && (r_sub_cnt == w_head);
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_axi_rd_burst_split.sv
// Bench for axi_rd_burst_split: directed scenarios plus random bursts against a
// burst-level model of the expected sub-bursts and merged R stream.
module tb_axi_rd_burst_split;
  localparam int MBL = 16;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
  } ar_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_axi_arid, m_axi_arid, s_axi_rid, m_axi_rid;
  logic [31:0] s_axi_araddr, m_axi_araddr, s_axi_rdata, m_axi_rdata;
  logic [7:0]  s_axi_arlen, m_axi_arlen;
  logic [2:0]  s_axi_arsize, m_axi_arsize, s_axi_arprot, m_axi_arprot;
  logic [1:0]  s_axi_arburst, m_axi_arburst, s_axi_rresp, m_axi_rresp;
  logic        s_axi_arlock, m_axi_arlock;
  logic [3:0]  s_axi_arcache, m_axi_arcache;
  logic        s_axi_arvalid, s_axi_arready, m_axi_arvalid, m_axi_arready;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic        dbg_state;

  ar_t         s_pack, m_pack;
  ar_t         exp_ar_q[$];
  logic [8:0]  exp_q[$];
  ar_t         sub_q[$];

  int          n_checks = 0, n_fail = 0;
  int          up_beat = 0, total_beats = 0, rlast_cnt = 0, log_n = 0, sl_beat = 0;
  logic [31:0] log_addr [64];
  logic [7:0]  log_len [64];
  int          ar_mode = 1;
  logic        r_enable = 1'b1, rr_rand = 1'b0;

  always #5 clk = ~clk;

  assign s_pack = ar_t'({s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
                         s_axi_arlock, s_axi_arcache, s_axi_arprot});
  assign m_pack = ar_t'({m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
                         m_axi_arlock, m_axi_arcache, m_axi_arprot});

  axi_rd_burst_split #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(8), .MAX_BURST_LEN(MBL), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .o_dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected sub-bursts: split an INCR request into MBL-beat pieces, last one short.
  task automatic model_ar(input ar_t r);
    int  beats;
    int  n;
    ar_t s;
    beats = int'(r.len) + 1;
    exp_q.push_back(9'(beats));
    if (r.burst == 2'b01 && beats > MBL) begin
      for (int k = 0; k * MBL < beats; k++) begin
        s      = r;
        n      = ((beats - k * MBL) > MBL) ? MBL : (beats - k * MBL);
        s.addr = r.addr + 32'(k * (MBL << r.size));
        s.len  = 8'(n - 1);
        exp_ar_q.push_back(s);
      end
    end else begin
      exp_ar_q.push_back(r);
    end
  endtask

  // Compare process: everything is sampled on the falling edge.
  initial begin
    logic stall_prev;
    ar_t  prev_ar, e;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (s_axi_arvalid && s_axi_arready) model_ar(s_pack);
        if (stall_prev) begin
          chk("m_arvalid_held", 64'(m_axi_arvalid), 64'd1);
          chk("m_ar_stable", 64'(m_pack), 64'(prev_ar));
        end
        stall_prev = m_axi_arvalid && !m_axi_arready;
        prev_ar    = m_pack;
        if (m_axi_arvalid && m_axi_arready) begin
          if (exp_ar_q.size() == 0) chk("m_ar_unexpected", 64'd1, 64'd0);
          else begin
            e = exp_ar_q.pop_front();
            chk("m_ar_addr", 64'(m_axi_araddr), 64'(e.addr));
            chk("m_ar_len", 64'(m_axi_arlen), 64'(e.len));
            chk("m_ar_fields", 64'(m_pack), 64'(e));
          end
          if (log_n < 64) begin
            log_addr[log_n] = m_axi_araddr;
            log_len[log_n]  = m_axi_arlen;
            log_n++;
          end
        end
        chk("m_rready", 64'(m_axi_rready), 64'(s_axi_rready));
        if (m_axi_rvalid) begin
          chk("s_rvalid", 64'(s_axi_rvalid), 64'd1);
          chk("s_rid", 64'(s_axi_rid), 64'(m_axi_rid));
          chk("s_rdata", 64'(s_axi_rdata), 64'(m_axi_rdata));
          chk("s_rresp", 64'(s_axi_rresp), 64'(m_axi_rresp));
          if (exp_q.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
          else begin
            chk("s_rlast", 64'(s_axi_rlast), 64'(up_beat + 1 == int'(exp_q[0])));
            if (s_axi_rready) begin
              up_beat++;
              total_beats++;
              if (s_axi_rlast) rlast_cnt++;
              if (up_beat == int'(exp_q[0])) begin
                up_beat = 0;
                void'(exp_q.pop_front());
              end
            end
          end
        end
      end
    end
  end

  // Downstream slave: accepts AR per ar_mode and returns sub-bursts in order.
  initial begin
    logic ar_take, r_take;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rid     = '0;
    m_axi_rdata   = '0;
    m_axi_rresp   = '0;
    m_axi_rlast   = 1'b0;
    forever begin
      @(negedge clk);
      ar_take = rst_n && m_axi_arvalid && m_axi_arready;
      if (ar_take) sub_q.push_back(m_pack);
      r_take = m_axi_rvalid && s_axi_rready;
      @(posedge clk);
      #1;
      case (ar_mode)
        0:       m_axi_arready = ($urandom_range(0, 3) != 0);
        1:       m_axi_arready = 1'b1;
        default: m_axi_arready = 1'b0;
      endcase
      if (!rst_n) begin
        m_axi_rvalid = 1'b0;
        sl_beat      = 0;
      end else begin
        if (r_take) begin
          m_axi_rvalid = 1'b0;
          if (m_axi_rlast) begin
            void'(sub_q.pop_front());
            sl_beat = 0;
          end else sl_beat++;
        end
        if (!m_axi_rvalid && r_enable && sub_q.size() > 0 && $urandom_range(0, 3) != 0) begin
          m_axi_rvalid = 1'b1;
          m_axi_rid    = sub_q[0].id;
          m_axi_rdata  = $urandom;
          m_axi_rresp  = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
          m_axi_rlast  = (sl_beat == int'(sub_q[0].len));
        end
      end
    end
  end

  initial begin
    s_axi_rready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      s_axi_rready = rr_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  task automatic send_ar(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    @(posedge clk);
    #1;
    s_axi_arid    = id;
    s_axi_araddr  = addr;
    s_axi_arlen   = len;
    s_axi_arsize  = size;
    s_axi_arburst = burst;
    s_axi_arlock  = 1'($urandom);
    s_axi_arcache = 4'($urandom);
    s_axi_arprot  = 3'($urandom);
    s_axi_arvalid = 1'b1;
    @(negedge clk);
    while (!s_axi_arready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!s_axi_arready) chk("ar_accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    s_axi_arvalid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || exp_ar_q.size() != 0) && t < 30000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 30000) chk("drain_timeout", 64'd0, 64'd1);
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_arready(input string name);
    int t = 0;
    @(negedge clk);
    while (!s_axi_arready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk(name, 64'(s_axi_arready), 64'd1);
  endtask

  task automatic clear_log();
    log_n       = 0;
    total_beats = 0;
    rlast_cnt   = 0;
  endtask

  initial begin
    int t;
    s_axi_arvalid = 1'b0;
    s_axi_arid    = '0;
    s_axi_araddr  = '0;
    s_axi_arlen   = '0;
    s_axi_arsize  = '0;
    s_axi_arburst = '0;
    s_axi_arlock  = 1'b0;
    s_axi_arcache = '0;
    s_axi_arprot  = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_s_arready", 64'(s_axi_arready), 64'd0);
    chk("rst_m_arvalid", 64'(m_axi_arvalid), 64'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    wait_arready("arready_after_reset");

    // 64-beat INCR -> four 16-beat sub-bursts
    clear_log();
    send_ar(8'h11, 32'h1000, 8'd63, 3'd2, 2'b01);
    drain();
    chk("t1_count", 64'(log_n), 64'd4);
    chk("t1_addr0", 64'(log_addr[0]), 64'h1000);
    chk("t1_addr1", 64'(log_addr[1]), 64'h1040);
    chk("t1_addr2", 64'(log_addr[2]), 64'h1080);
    chk("t1_addr3", 64'(log_addr[3]), 64'h10C0);
    chk("t1_len3", 64'(log_len[3]), 64'd15);
    chk("t1_beats", 64'(total_beats), 64'd64);
    chk("t1_rlasts", 64'(rlast_cnt), 64'd1);

    // 21-beat INCR at size 3 -> 16 + 5
    clear_log();
    send_ar(8'h22, 32'h2004, 8'd20, 3'd3, 2'b01);
    drain();
    chk("t2_count", 64'(log_n), 64'd2);
    chk("t2_addr0", 64'(log_addr[0]), 64'h2004);
    chk("t2_len0", 64'(log_len[0]), 64'd15);
    chk("t2_addr1", 64'(log_addr[1]), 64'h2084);
    chk("t2_len1", 64'(log_len[1]), 64'd4);
    chk("t2_beats", 64'(total_beats), 64'd21);
    chk("t2_rlasts", 64'(rlast_cnt), 64'd1);

    // FIXED 32 beats and single-beat INCR pass unchanged
    clear_log();
    send_ar(8'h33, 32'h3000, 8'd31, 3'd2, 2'b00);
    send_ar(8'h44, 32'h4000, 8'd0, 3'd2, 2'b01);
    drain();
    chk("t3_count", 64'(log_n), 64'd2);
    chk("t3_len0", 64'(log_len[0]), 64'd31);
    chk("t3_addr1", 64'(log_addr[1]), 64'h4000);
    chk("t3_rlasts", 64'(rlast_cnt), 64'd2);

    // Downstream AR stalled for 10 cycles mid-split
    @(negedge clk) ar_mode = 2;
    clear_log();
    send_ar(8'h55, 32'h5000, 8'd63, 3'd2, 2'b01);
    repeat (10) @(posedge clk);
    @(negedge clk) ar_mode = 1;
    drain();
    chk("t4_count", 64'(log_n), 64'd4);
    chk("t4_addr3", 64'(log_addr[3]), 64'h50C0);

    // Tracking FIFO full with R held off
    @(negedge clk) r_enable = 1'b0;
    clear_log();
    for (int i = 0; i < 4; i++) send_ar(8'(i), 32'h6000 + 32'(i * 64), 8'd0, 3'd2, 2'b01);
    @(posedge clk);
    #1;
    s_axi_arid    = 8'h05;
    s_axi_araddr  = 32'h6100;
    s_axi_arlen   = 8'd0;
    s_axi_arburst = 2'b01;
    s_axi_arvalid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("full_arready_low", 64'(s_axi_arready), 64'd0);
    end
    r_enable = 1'b1;
    rr_rand  = 1'b1;
    t = 0;
    @(negedge clk);
    while (!s_axi_arready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("full_released", 64'(s_axi_arready), 64'd1);
    chk("full_after_rlast", 64'(rlast_cnt >= 1), 64'd1);
    @(posedge clk);
    #1 s_axi_arvalid = 1'b0;
    drain();
    chk("t5_rlasts", 64'(rlast_cnt), 64'd5);

    // Asynchronous reset in the middle of a split
    rr_rand = 1'b0;
    @(negedge clk) ar_mode = 2;
    send_ar(8'h77, 32'h7000, 8'd63, 3'd2, 2'b01);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_m_arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("midrst_s_arready", 64'(s_axi_arready), 64'd0);
    repeat (2) @(posedge clk);
    #3;
    exp_ar_q.delete();
    exp_q.delete();
    sub_q.delete();
    up_beat = 0;
    sl_beat = 0;
    ar_mode = 1;
    rst_n   = 1'b1;
    wait_arready("arready_after_midrst");
    clear_log();
    send_ar(8'h88, 32'h8000, 8'd31, 3'd2, 2'b01);
    drain();
    chk("t6_count", 64'(log_n), 64'd2);
    chk("t6_addr1", 64'(log_addr[1]), 64'h8040);
    chk("t6_len1", 64'(log_len[1]), 64'd15);
    chk("t6_rlasts", 64'(rlast_cnt), 64'd1);

    // Random traffic under random backpressure on both sides
    @(negedge clk) ar_mode = 0;
    rr_rand = 1'b1;
    for (int i = 0; i < 30; i++) begin
      logic [1:0] b;
      logic [7:0] l;
      b = ($urandom_range(0, 4) == 0) ? 2'b00 : 2'b01;
      l = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
      if (b == 2'b00) l = 8'($urandom_range(0, 15));
      send_ar(8'($urandom), $urandom, l, 3'($urandom_range(0, 2)), b);
    end
    drain();
    chk("random_drained", 64'(exp_q.size() + exp_ar_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
